// File: rtl/permission_requester_if.sv
// ============================================================================
// permission_requester_if
// Request, checker and actuator signals of the permission requester.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface permission_requester_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] user_code;
  logic [2:0] op_code;
  logic       cancel;
  logic [5:0] chk_lines;
  logic       chk_permit;
  logic       run_en;
  logic       resp_valid;
  logic       resp_grant;
  logic       resp_abort;
  logic       busy;

  // Front end plus checker side.
  modport master (
    output req_valid, user_code, op_code, cancel, chk_permit,
    input  req_ready, chk_lines, run_en, resp_valid, resp_grant, resp_abort, busy
  );

  // Requester block side.
  modport slave (
    input  req_valid, user_code, op_code, cancel, chk_permit,
    output req_ready, chk_lines, run_en, resp_valid, resp_grant, resp_abort, busy
  );
endinterface

`default_nettype wire

// File: rtl/permission_requester.sv
// ============================================================================
// permission_requester
// Drives A..F to the permission checker, samples permit, then runs or denies.
// Optional feature macro: PERM_LOCKOUT_EN (16-cycle lockout after 3 denials).
// Revision: 1.0
// ============================================================================
`default_nettype none

module permission_requester #(
  parameter int SETTLE_CYCLES = 1,
  parameter int RUN_CYCLES    = 8,
  parameter int CNT_W         = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  permission_requester_if.slave bus_if
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
`ifdef PERM_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(15);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_RUN    = 3'd3,
    S_RESP   = 3'd4
`ifdef PERM_LOCKOUT_EN
    ,
    S_LOCK   = 3'd5
`endif
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q;
  logic [5:0]       chk_lines_q;
  logic             run_en_q;
  logic             resp_valid_q;
  logic             resp_grant_q;
  logic             resp_abort_q;
  logic             busy_q;
`ifdef PERM_LOCKOUT_EN
  logic [1:0]       deny_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      chk_lines_q  <= '0;
      run_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_grant_q <= 1'b0;
      resp_abort_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PERM_LOCKOUT_EN
      deny_cnt_q   <= 2'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            // A null operation is denied without ever touching the checker.
            if (bus_if.op_code == 3'b000) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_grant_q <= 1'b0;
              resp_abort_q <= 1'b0;
            end else begin
              state_q     <= S_DRIVE;
              chk_lines_q <= {bus_if.user_code, bus_if.op_code};
            end
          end
        end

        S_DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_SAMPLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          cnt_q <= '0;
          if (bus_if.chk_permit) begin
            state_q  <= S_RUN;
            run_en_q <= 1'b1;
          end else begin
            state_q      <= S_RESP;
            chk_lines_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_grant_q <= 1'b0;
            resp_abort_q <= 1'b0;
          end
        end

        S_RUN: begin
          // Cancel and revocation both end the run early; cancel has priority.
          if (bus_if.cancel || !bus_if.chk_permit || (cnt_q == RUN_LAST)) begin
            state_q      <= S_RESP;
            run_en_q     <= 1'b0;
            chk_lines_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_grant_q <= 1'b1;
            resp_abort_q <= bus_if.cancel || !bus_if.chk_permit;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_grant_q <= 1'b0;
          resp_abort_q <= 1'b0;
          cnt_q        <= '0;
`ifdef PERM_LOCKOUT_EN
          if (resp_grant_q) begin
            deny_cnt_q  <= 2'd0;
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (deny_cnt_q == 2'd2) begin
            state_q <= S_LOCK;
          end else begin
            deny_cnt_q  <= deny_cnt_q + 2'd1;
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
`else
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
`endif
        end

`ifdef PERM_LOCKOUT_EN
        S_LOCK: begin
          if (cnt_q == LOCK_LAST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            deny_cnt_q  <= 2'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif

        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          req_ready_q  <= 1'b1;
          chk_lines_q  <= '0;
          run_en_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          resp_grant_q <= 1'b0;
          resp_abort_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.req_ready  = req_ready_q;
  assign bus_if.chk_lines  = chk_lines_q;
  assign bus_if.run_en     = run_en_q;
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_grant = resp_grant_q;
  assign bus_if.resp_abort = resp_abort_q;
  assign bus_if.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_permission_requester.sv
// ============================================================================
// tb_permission_requester
// Randomized self-checking bench with a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_permission_requester;

  localparam int S    = 1;
  localparam int R    = 8;
  localparam int NONE = 999;

  logic clk;
  logic rst_n;
  logic revoke;
  int   n_checks;
  int   n_errors;
  int   deny_cnt;

  permission_requester_if bus_if ();

  permission_requester #(
    .SETTLE_CYCLES (S),
    .RUN_CYCLES    (R),
    .CNT_W         (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker model: a user and an op must both be non-zero; user 111 may not run ops 1xx.
  function automatic logic perm(input logic [5:0] l);
    return (l[5:3] != 3'b000) && (l[2:0] != 3'b000) && !(l[5:3] == 3'b111 && l[2]);
  endfunction

  assign bus_if.chk_permit = perm(bus_if.chk_lines) && !revoke;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction outcome from the protocol rules: latency, grant, abort, run_en cycles.
  task automatic model(input logic [2:0] u, input logic [2:0] o, input int c_at, input int r_at,
                       output int lat, output logic g, output logic a, output int runs);
    int k;
    if (o == 3'b000) begin
      lat = 1; g = 1'b0; a = 1'b0; runs = 0;
    end else if (!perm({u, o})) begin
      lat = S + 2; g = 1'b0; a = 1'b0; runs = 0;
    end else begin
      k = R;
      if (c_at >= 0 && c_at < k) k = c_at;
      if (r_at >= 0 && r_at < k) k = r_at;
      g = 1'b1;
      if (k < R) begin
        a = 1'b1; runs = k + 1; lat = S + 2 + k + 1;
      end else begin
        a = 1'b0; runs = R; lat = S + 2 + R;
      end
    end
  endtask

  // Called right after an accept edge; follows the transaction to its response.
  task automatic track(input logic [2:0] u, input logic [2:0] o, input int c_at, input int r_at);
    int lat_e, runs_e, n, runs, line_bad, rdy_bad, lock;
    logic g_e, a_e, seen, g, a;
    logic [5:0] exp_lines;
    model(u, o, c_at, r_at, lat_e, g_e, a_e, runs_e);
    seen = 1'b0; g = 1'b0; a = 1'b0;
    n = 0; runs = 0; line_bad = 0; rdy_bad = 0;
    while (!seen && n < 300) begin
      n++;
      @(negedge clk);
      bus_if.cancel = (c_at != NONE) && (n == S + 2 + c_at);
      revoke        = (r_at != NONE) && (n == S + 2 + r_at);
      if (bus_if.run_en === 1'b1) runs++;
      exp_lines = (o == 3'b000 || n >= lat_e) ? 6'd0 : {u, o};
      if (bus_if.chk_lines !== exp_lines) line_bad++;
      if (bus_if.req_ready !== 1'b0 || bus_if.busy !== 1'b1) rdy_bad++;
      if (bus_if.resp_valid === 1'b1) begin
        seen = 1'b1; g = bus_if.resp_grant; a = bus_if.resp_abort;
      end
    end
    check_eq("resp_seen", seen, 1);
    check_eq("latency", n, lat_e);
    check_eq("grant", g, g_e);
    check_eq("abort", a, a_e);
    check_eq("run_cycles", runs, runs_e);
    check_eq("lines_bad", line_bad, 0);
    check_eq("busy_bad", rdy_bad, 0);
    @(negedge clk);
    bus_if.cancel = 1'b0;
    revoke        = 1'b0;
    check_eq("resp_once", bus_if.resp_valid, 0);
`ifdef PERM_LOCKOUT_EN
    if (g_e) deny_cnt = 0; else deny_cnt++;
    if (deny_cnt == 3) begin
      deny_cnt = 0;
      lock = 0;
      while (bus_if.req_ready === 1'b0 && bus_if.busy === 1'b1 && lock < 40) begin
        lock++;
        @(negedge clk);
      end
      check_eq("lock_len", lock, 16);
    end
`endif
    check_eq("idle_ready", {bus_if.req_ready, bus_if.busy}, 2'b10);
  endtask

  task automatic send(input logic [2:0] u, input logic [2:0] o, input int c_at, input int r_at,
                      input logic hold);
    int w;
    bus_if.user_code = u;
    bus_if.op_code   = o;
    bus_if.req_valid = 1'b1;
    w = 0;
    while (bus_if.req_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_ready", bus_if.req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) bus_if.req_valid = 1'b0;
    track(u, o, c_at, r_at);
  endtask

  task automatic reset_mid_run();
    int w, rv_bad;
    bus_if.user_code = 3'b101;
    bus_if.op_code   = 3'b001;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    w = 0;
    while (bus_if.run_en !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("rst_run_reached", bus_if.run_en, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_run_en", bus_if.run_en, 0);
    check_eq("rst_busy", bus_if.busy, 0);
    check_eq("rst_lines", bus_if.chk_lines, 0);
    check_eq("rst_ready", bus_if.req_ready, 1);
    rv_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid !== 1'b0) rv_bad++;
    end
    rst_n = 1'b1;
    deny_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid !== 1'b0 || bus_if.busy !== 1'b0) rv_bad++;
    end
    check_eq("rst_no_resp", rv_bad, 0);
  endtask

  initial begin
    logic [2:0] u, o;
    int c_at, r_at;
    n_checks = 0; n_errors = 0; deny_cnt = 0;
    revoke = 1'b0;
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.user_code = 3'b000;
    bus_if.op_code   = 3'b000;
    bus_if.cancel    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", bus_if.req_ready, 1);
    check_eq("reset_outs", {bus_if.busy, bus_if.run_en, bus_if.resp_valid,
                            bus_if.resp_grant, bus_if.resp_abort, bus_if.chk_lines}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(3'b101, 3'b001, NONE, NONE, 1'b0);
    send(3'b110, 3'b001, NONE, NONE, 1'b0);
    send(3'b000, 3'b001, NONE, NONE, 1'b0);
    send(3'b011, 3'b000, -2,   NONE, 1'b0);
    send(3'b101, 3'b010, 2,    NONE, 1'b0);
    send(3'b101, 3'b010, NONE, 3,    1'b0);
    send(3'b101, 3'b010, -2,   NONE, 1'b0);

    // Request held through a whole run: second accept only once back in IDLE.
    send(3'b101, 3'b001, NONE, NONE, 1'b1);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    track(3'b101, 3'b001, NONE, NONE);

    reset_mid_run();

`ifdef PERM_LOCKOUT_EN
    send(3'b000, 3'b100, NONE, NONE, 1'b0);
    send(3'b000, 3'b100, NONE, NONE, 1'b0);
    send(3'b000, 3'b100, NONE, NONE, 1'b0);
    send(3'b000, 3'b100, NONE, NONE, 1'b0);
    send(3'b101, 3'b001, NONE, NONE, 1'b0);
    send(3'b000, 3'b100, NONE, NONE, 1'b0);
    send(3'b000, 3'b000, NONE, NONE, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      u = 3'($urandom_range(0, 7));
      o = 3'($urandom_range(0, 7));
      c_at = ($urandom_range(0, 2) == 0) ? NONE : int'($urandom_range(0, R + 2)) - 2;
      r_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, R)) : NONE;
      send(u, o, c_at, r_at, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/permission_requester.md
Name: permission_requester

Overview:
Initiator side of the six-bit permission check interface. Accepts a user request (3-bit user code, 3-bit operation code) over a valid/ready handshake and drives the A..F lines to the combinational permission checker. After a settle window it samples the checker's permit line, then either runs the operation for a timed window with continuous permit monitoring, or returns a denial. Sits between the user-input front end and the actuator enables of the product.

Parameters:
SETTLE_CYCLES, 1, cycles chk_lines are held stable before permit is sampled (range 1..15)
RUN_CYCLES, 8, cycles run_en stays high on a grant (range 1..255)
CNT_W, 8, width of the internal cycle counter; must hold max(SETTLE_CYCLES, RUN_CYCLES, 16)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
user_code  input  3  {A,B,C}, captured on accept
op_code  input  3  {D,E,F}, captured on accept
cancel  input  1  user abort, honoured only in RUN
chk_lines  output  6  {A,B,C,D,E,F} driven to the checker
chk_permit  input  1  checker result
run_en  output  1  actuator enable
resp_valid  output  1  one-cycle response strobe
resp_grant  output  1  1 = operation was granted, qualified by resp_valid
resp_abort  output  1  1 = granted run ended early (cancel or permit loss), qualified by resp_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Reset forces state IDLE, counter 0, and all outputs 0, except req_ready, which is 1 after reset.
- States: IDLE, DRIVE, SAMPLE, RUN, RESP.
- IDLE: req_ready=1 and chk_lines=0, so D/E/F are all zero and the checker reports no permit.
  - Accept happens on any edge where req_valid=1 and req_ready=1. The block registers user_code and op_code.
  - If the captured op_code==000, go to RESP with grant=0 and skip the checker.
  - Otherwise go to DRIVE with counter=0.
- DRIVE: chk_lines = captured {user,op}. The block stays for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: one cycle. chk_permit is registered at the end of this cycle.
  - permit=1 → RUN, counter=0.
  - permit=0 → RESP with grant=0, abort=0.
- RUN: run_en=1 and chk_lines are still driven. Priority each cycle:
  1. cancel=1 → RESP with grant=1, abort=1.
  2. chk_permit=0 (revocation) → RESP with grant=1, abort=1.
  3. counter==RUN_CYCLES-1 → RESP with grant=1, abort=0.
  4. Otherwise the counter increments.
  - On the cycle that leaves RUN, run_en is still 1. It is 0 from RESP onward.
- RESP: resp_valid=1 for exactly one cycle with resp_grant and resp_abort valid. chk_lines=0. Next state is IDLE.
- req_ready=0 in every state except IDLE. A request held during busy waits and is never dropped or double-accepted.
- Latency, measured from the accept edge to resp_valid high:
  - op_code 000: 1 cycle.
  - Deny: SETTLE_CYCLES+2 cycles.
  - Full grant: SETTLE_CYCLES+2+RUN_CYCLES cycles.
- cancel outside RUN is ignored.
- Reset asserted mid-operation drops run_en and chk_lines immediately (asynchronous). No response is issued.
- Counter never wraps. It is only compared below its terminal value.

Optional Feature:
PERM_LOCKOUT_EN
- When defined: a 2-bit count of consecutive denials (resp_grant=0) is kept.
  - Any grant clears the count.
  - On the third consecutive denial, the block enters LOCK after RESP. LOCK lasts 16 cycles with req_ready=0 and busy=1, then the block returns to IDLE and the count clears.
  - op_code 000 denials count toward the lockout.
- When not defined: no LOCK state and no count. RESP always goes to IDLE.

Test Plan:
- Reset, then user 101 op 001, SETTLE=1, RUN=8 → chk_lines=101001; run_en high for 8 cycles; resp_valid at accept+11 with grant=1, abort=0.
- User 110 op 001 → granted (checker permits A,B,!C,!D,!E,F). User 000 op 001 → resp at accept+3 with grant=0; run_en never high.
- op 000, any user → resp at accept+1 with grant=0; chk_lines stay 0 throughout.
- User 101 op 010, cancel pulsed on the 3rd RUN cycle → run_en drops the next cycle; resp grant=1, abort=1. Repeat with the checker model forcing chk_permit=0 mid-RUN → same response.
- req_valid held high through a granted run → exactly one accept; a second accept only after returning to IDLE. Asserting rst_n=0 in RUN → run_en=0 and busy=0 immediately; no resp_valid.
- With PERM_LOCKOUT_EN defined: three requests of user 000 op 100 → three denials, then req_ready=0 for 16 cycles; a grant between denials resets the count and causes no lockout.
